// File: rtl/decode_prefix_pkg.sv
// decode_prefix_pkg: prefix byte codes, segment indices, rep/state/kind enums and the prefix record
package decode_prefix_pkg;

    localparam logic [7:0] PFX_LOCK     = 8'hF0;
    localparam logic [7:0] PFX_REPNE    = 8'hF2;
    localparam logic [7:0] PFX_REPE     = 8'hF3;
    localparam logic [7:0] PFX_OPSIZE   = 8'h66;
    localparam logic [7:0] PFX_ADDRSIZE = 8'h67;
    localparam logic [7:0] PFX_SEG_ES   = 8'h26;
    localparam logic [7:0] PFX_SEG_CS   = 8'h2E;
    localparam logic [7:0] PFX_SEG_SS   = 8'h36;
    localparam logic [7:0] PFX_SEG_DS   = 8'h3E;
    localparam logic [7:0] PFX_SEG_FS   = 8'h64;
    localparam logic [7:0] PFX_SEG_GS   = 8'h65;

    localparam logic [2:0] index_reg_seg__ES = 3'd0;
    localparam logic [2:0] index_reg_seg__CS = 3'd1;
    localparam logic [2:0] index_reg_seg__SS = 3'd2;
    localparam logic [2:0] index_reg_seg__DS = 3'd3;
    localparam logic [2:0] index_reg_seg__FS = 3'd4;
    localparam logic [2:0] index_reg_seg__GS = 3'd5;

    // Record count field is wide enough for any practical MAX_PREFIX; the top slices it to CNT_W.
    localparam int REC_CNT_W = 8;

    typedef enum logic [1:0] {REP_NONE = 2'b00, REP_NE = 2'b10, REP_E = 2'b11} rep_e;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PREFIX = 2'd1, S_HOLD = 2'd2} state_e;
    typedef enum logic [2:0] {K_OPCODE, K_LOCK, K_REP, K_OPSIZE, K_ADDRSIZE, K_SEG} kind_e;

    typedef struct packed {
        logic                 lock;
        rep_e                 rep;
        logic                 seg_override;
        logic [2:0]           seg_index;
        logic                 opsize;
        logic                 addrsize;
        logic [REC_CNT_W-1:0] count;
        logic                 fault;
    } prefix_record_t;

    // Jcc short forms and the two-byte escape that leads to Jcc near.
    function automatic logic is_branch_opcode(input logic [7:0] b);
        return (b[7:4] == 4'h7) || (b == 8'h0F);
    endfunction

endpackage

// File: rtl/decode_prefix_accumulator_if.sv
// decode_prefix_accumulator_if: byte-in / record-out handshake bundle
//   slave  : accumulator side (consumes i_*, drives o_*)
//   master : upstream byte queue + downstream decoder side
interface decode_prefix_accumulator_if #(parameter int CNT_W = 4);
    logic             i_flush;
    logic [7:0]       i_byte;
    logic             i_valid;
    logic             o_ready;
    logic             i_default_32;
    logic             o_valid;
    logic             i_ready;
    logic [7:0]       o_opcode;
    logic             o_lock;
    logic [1:0]       o_rep;
    logic             o_seg_override;
    logic [2:0]       o_seg_index;
    logic             o_operand_32;
    logic             o_address_32;
    logic [CNT_W-1:0] o_prefix_count;
    logic             o_fault;
    logic             o_hint_taken;
    logic             o_hint_not_taken;
    modport slave (
        input  i_flush, i_byte, i_valid, i_default_32, i_ready,
        output o_ready, o_valid, o_opcode, o_lock, o_rep, o_seg_override, o_seg_index,
               o_operand_32, o_address_32, o_prefix_count, o_fault, o_hint_taken, o_hint_not_taken
    );
    modport master (
        output i_flush, i_byte, i_valid, i_default_32, i_ready,
        input  o_ready, o_valid, o_opcode, o_lock, o_rep, o_seg_override, o_seg_index,
               o_operand_32, o_address_32, o_prefix_count, o_fault, o_hint_taken, o_hint_not_taken
    );
endinterface

// File: rtl/decode_prefix_classify.sv
// decode_prefix_classify: combinational byte -> {is_prefix, kind, seg_index}
//   i_byte      : instruction byte
//   o_is_prefix : byte is one of the recognised prefixes
//   o_kind      : prefix class (K_OPCODE for non-prefix bytes)
//   o_seg_index : segment register index for segment prefixes, else 0
module decode_prefix_classify
    import decode_prefix_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_prefix,
    output kind_e      o_kind,
    output logic [2:0] o_seg_index
);
    always_comb begin
        o_kind      = K_OPCODE;
        o_seg_index = 3'd0;
        case (i_byte)
            PFX_LOCK:            o_kind = K_LOCK;
            PFX_REPNE, PFX_REPE: o_kind = K_REP;
            PFX_OPSIZE:          o_kind = K_OPSIZE;
            PFX_ADDRSIZE:        o_kind = K_ADDRSIZE;
            PFX_SEG_ES: begin o_kind = K_SEG; o_seg_index = index_reg_seg__ES; end
            PFX_SEG_CS: begin o_kind = K_SEG; o_seg_index = index_reg_seg__CS; end
            PFX_SEG_SS: begin o_kind = K_SEG; o_seg_index = index_reg_seg__SS; end
            PFX_SEG_DS: begin o_kind = K_SEG; o_seg_index = index_reg_seg__DS; end
            PFX_SEG_FS: begin o_kind = K_SEG; o_seg_index = index_reg_seg__FS; end
            PFX_SEG_GS: begin o_kind = K_SEG; o_seg_index = index_reg_seg__GS; end
            default: ;
        endcase
        o_is_prefix = (o_kind != K_OPCODE);
    end
endmodule

// File: rtl/decode_prefix_accumulator.sv
// decode_prefix_accumulator: folds a run of x86 prefix bytes into one record emitted with its opcode
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : byte stream in (i_byte/i_valid/o_ready), record out (o_valid/i_ready + fields),
//                  i_flush, i_default_32, branch hints
//   Optional: DECODE_PREFIX_BRANCH_HINT_EN builds the 2E/3E branch hint outputs.
module decode_prefix_accumulator
    import decode_prefix_pkg::*;
#(
    parameter int MAX_PREFIX = 14,
    parameter int CNT_W      = $clog2(MAX_PREFIX + 1)
) (
    input logic                        i_clk,
    input logic                        i_rst,
    decode_prefix_accumulator_if.slave bus
);
    state_e         r_state;
    prefix_record_t r_rec;
    logic [7:0]     r_opcode;
    logic           r_valid, r_op32, r_addr32, r_live;
    prefix_record_t w_base, w_next;
    logic           w_is_prefix, w_accept, w_full;
    kind_e          w_kind;
    logic [2:0]     w_seg_index;

    decode_prefix_classify u_classify (
        .i_byte      (bus.i_byte),
        .o_is_prefix (w_is_prefix),
        .o_kind      (w_kind),
        .o_seg_index (w_seg_index)
    );

    // r_live keeps o_ready low until the first edge after reset releases.
    assign bus.o_ready = r_live & ~bus.i_flush & ((r_state != S_HOLD) | bus.i_ready);
    assign w_accept    = bus.i_valid & bus.o_ready;
    // A byte accepted while a record is being handed off starts from a clean accumulator.
    assign w_base      = (r_state == S_HOLD) ? '0 : r_rec;
    assign w_full      = (w_base.count == REC_CNT_W'(MAX_PREFIX));

    always_comb begin
        w_next       = w_base;
        w_next.count = w_base.count + 1'b1;
        case (w_kind)
            K_LOCK:     w_next.lock     = 1'b1;
            K_REP:      w_next.rep      = bus.i_byte[0] ? REP_E : REP_NE;
            K_OPSIZE:   w_next.opsize   = 1'b1;
            K_ADDRSIZE: w_next.addrsize = 1'b1;
            K_SEG: begin
                w_next.seg_override = 1'b1;
                w_next.seg_index    = w_seg_index;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_rec    <= '0;
            r_opcode <= '0;
            r_op32   <= 1'b0;
            r_addr32 <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (bus.i_flush || (!w_accept && r_valid && bus.i_ready)) begin
                r_state  <= S_IDLE;
                r_valid  <= 1'b0;
                r_rec    <= '0;
                r_opcode <= '0;
                r_op32   <= 1'b0;
                r_addr32 <= 1'b0;
            end else if (w_accept && w_is_prefix && !w_full) begin
                r_state <= S_PREFIX;
                r_valid <= 1'b0;
                r_rec   <= w_next;
            end else if (w_accept) begin
                // Opcode byte, or an overflowing prefix that is surfaced as the opcode with a fault.
                r_state   <= S_HOLD;
                r_valid   <= 1'b1;
                r_rec     <= w_base;
                r_rec.fault <= w_is_prefix;
                r_opcode  <= bus.i_byte;
                r_op32    <= bus.i_default_32 ^ w_base.opsize;
                r_addr32  <= bus.i_default_32 ^ w_base.addrsize;
            end
        end
    end

    assign bus.o_valid        = r_valid;
    assign bus.o_opcode       = r_opcode;
    assign bus.o_lock         = r_rec.lock;
    assign bus.o_rep          = r_rec.rep;
    assign bus.o_seg_override = r_rec.seg_override;
    assign bus.o_seg_index    = r_rec.seg_index;
    assign bus.o_operand_32   = r_op32;
    assign bus.o_address_32   = r_addr32;
    assign bus.o_prefix_count = r_rec.count[CNT_W-1:0];
    assign bus.o_fault        = r_rec.fault;

`ifdef DECODE_PREFIX_BRANCH_HINT_EN
    logic r_hint_t, r_hint_nt, w_hint_branch;
    assign w_hint_branch = w_base.seg_override & is_branch_opcode(bus.i_byte);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hint_t  <= 1'b0;
            r_hint_nt <= 1'b0;
        end else if (bus.i_flush || (!w_accept && r_valid && bus.i_ready)) begin
            r_hint_t  <= 1'b0;
            r_hint_nt <= 1'b0;
        end else if (w_accept) begin
            // Only meaningful when the byte closes a record; cleared otherwise so no stale hint lingers.
            r_hint_t  <= (!w_is_prefix || w_full) && w_hint_branch && (w_base.seg_index == index_reg_seg__DS);
            r_hint_nt <= (!w_is_prefix || w_full) && w_hint_branch && (w_base.seg_index == index_reg_seg__CS);
        end
    end

    assign bus.o_hint_taken     = r_hint_t;
    assign bus.o_hint_not_taken = r_hint_nt;
`else
    assign bus.o_hint_taken     = 1'b0;
    assign bus.o_hint_not_taken = 1'b0;
`endif
endmodule

// File: tb/tb_decode_prefix_accumulator.sv
// tb_decode_prefix_accumulator: scoreboard bench with a list-based prefix model
module tb_decode_prefix_accumulator;
    localparam int MAXP = 14;
    localparam int CW   = 4;

    typedef struct {
        logic [7:0] op;
        logic       lock;
        logic [1:0] rep;
        logic       so;
        logic [2:0] si;
        logic       o32, a32;
        int         cnt;
        logic       fault, ht, hnt;
        int         vis;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_prefix_accumulator_if #(.CNT_W(CW)) bus ();
    decode_prefix_accumulator #(.MAX_PREFIX(MAXP), .CNT_W(CW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    exp_t       q[$];
    logic [7:0] pend[$];
    int         cyc = 0;
    int         n_chk = 0, n_pass = 0;
    logic       live = 1'b0;
    logic [7:0] pfx_tab [11] = '{8'hF0, 8'hF2, 8'hF3, 8'h66, 8'h67, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic is_pfx(input logic [7:0] b);
        foreach (pfx_tab[i]) if (pfx_tab[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Expected record built from the list of prefix bytes seen since the last record.
    function automatic exp_t build(input logic [7:0] op, input logic def, input logic fault, input int vis);
        exp_t e;
        logic os = 0, as = 0;
        logic [7:0] lastseg = 8'h00;
        logic jcc;
        e = '{default: '0};
        foreach (pend[i]) begin
            case (pend[i])
                8'hF0: e.lock = 1;
                8'hF2: e.rep = 2'b10;
                8'hF3: e.rep = 2'b11;
                8'h66: os = 1;
                8'h67: as = 1;
                default: lastseg = pend[i];
            endcase
        end
        e.so = (lastseg != 8'h00);
        case (lastseg)
            8'h2E: e.si = 3'd1;
            8'h36: e.si = 3'd2;
            8'h3E: e.si = 3'd3;
            8'h64: e.si = 3'd4;
            8'h65: e.si = 3'd5;
            default: e.si = 3'd0;
        endcase
        e.op = op; e.o32 = def ^ os; e.a32 = def ^ as;
        e.cnt = pend.size(); e.fault = fault; e.vis = vis;
        jcc = (op >= 8'h70 && op <= 8'h7F) || op == 8'h0F;
`ifdef DECODE_PREFIX_BRANCH_HINT_EN
        e.ht  = jcc && lastseg == 8'h3E;
        e.hnt = jcc && lastseg == 8'h2E;
`else
        e.ht  = 1'b0 & jcc;
        e.hnt = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic exp_valid();
        return q.size() > 0 && q[0].vis <= cyc;
    endfunction

    task automatic step(input logic v, input logic [7:0] b, input logic def, input logic rdy, input logic fl);
        @(negedge clk);
        bus.i_valid = v; bus.i_byte = b; bus.i_default_32 = def; bus.i_ready = rdy; bus.i_flush = fl;
        #1;
        if (live) chk("o_ready", bus.o_ready, !fl && (!exp_valid() || rdy));
        if (fl) pend.delete();
        else if (v && bus.o_ready) begin
            if (is_pfx(b) && pend.size() < MAXP) pend.push_back(b);
            else begin
                q.push_back(build(b, def, is_pfx(b), cyc + 1));
                pend.delete();
            end
        end
    endtask

    // Monitor: compares the held record against the scoreboard head every cycle.
    initial begin
        exp_t e;
        logic ev;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                ev = exp_valid();
                chk("o_valid", bus.o_valid, ev);
                if (ev && bus.o_valid) begin
                    e = q[0];
                    chk("o_opcode", bus.o_opcode, e.op);
                    chk("o_lock", bus.o_lock, e.lock);
                    chk("o_rep", bus.o_rep, e.rep);
                    chk("o_seg_override", bus.o_seg_override, e.so);
                    chk("o_seg_index", bus.o_seg_index, e.si);
                    chk("o_operand_32", bus.o_operand_32, e.o32);
                    chk("o_address_32", bus.o_address_32, e.a32);
                    chk("o_prefix_count", bus.o_prefix_count, e.cnt);
                    chk("o_fault", bus.o_fault, e.fault);
                    chk("o_hint_taken", bus.o_hint_taken, e.ht);
                    chk("o_hint_not_taken", bus.o_hint_not_taken, e.hnt);
                    if (bus.i_ready || bus.i_flush) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bus.i_valid = 0; bus.i_byte = 0; bus.i_default_32 = 0; bus.i_ready = 0; bus.i_flush = 0;
        #12;
        chk("reset o_valid", bus.o_valid, 0);
        chk("reset o_ready", bus.o_ready, 0);
        chk("reset o_opcode", bus.o_opcode, 0);
        chk("reset o_rep", bus.o_rep, 0);
        chk("reset o_prefix_count", bus.o_prefix_count, 0);
        chk("reset o_fault", bus.o_fault, 0);
        chk("reset hints", {bus.o_hint_taken, bus.o_hint_not_taken}, 0);
        @(negedge clk); rst = 0; #1;
        chk("o_ready before first edge", bus.o_ready, 0);
        @(posedge clk); #1;
        chk("o_ready after first edge", bus.o_ready, 1);
        live = 1;

        // 66 2E 8B, default 32
        step(1, 8'h66, 1, 0, 0); step(1, 8'h2E, 1, 0, 0); step(1, 8'h8B, 1, 0, 0); step(0, 0, 1, 0, 0);
        chk("t1 valid", bus.o_valid, 1);
        chk("t1 opcode", bus.o_opcode, 8'h8B);
        chk("t1 operand_32", bus.o_operand_32, 0);
        chk("t1 seg", {bus.o_seg_override, bus.o_seg_index}, 4'b1001);
        chk("t1 count", bus.o_prefix_count, 2);
        // held three cycles, then handoff together with byte 90
        step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0);
        chk("t4 ready low", bus.o_ready, 0);
        step(1, 8'h90, 0, 1, 0); step(0, 0, 0, 0, 0);
        chk("t4 opcode", bus.o_opcode, 8'h90);
        chk("t4 count", bus.o_prefix_count, 0);
        step(0, 0, 0, 1, 0);

        // F2 F3 26 64 A4
        foreach (pfx_tab[i]) ; // keep table referenced order-independent
        step(1, 8'hF2, 0, 0, 0); step(1, 8'hF3, 0, 0, 0); step(1, 8'h26, 0, 0, 0);
        step(1, 8'h64, 0, 0, 0); step(1, 8'hA4, 0, 0, 0); step(0, 0, 0, 0, 0);
        chk("t2 rep", bus.o_rep, 2'b11);
        chk("t2 seg_index", bus.o_seg_index, 3'd4);
        chk("t2 count", bus.o_prefix_count, 4);
        step(0, 0, 0, 1, 0);

        // 15 x 66 overflow
        for (int i = 0; i < 15; i++) step(1, 8'h66, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t3 fault", bus.o_fault, 1);
        chk("t3 opcode", bus.o_opcode, 8'h66);
        chk("t3 count", bus.o_prefix_count, MAXP);
        step(0, 0, 0, 1, 0);

        // flush after F0 67
        step(1, 8'hF0, 1, 0, 0); step(1, 8'h67, 1, 0, 0); step(1, 8'h11, 1, 0, 1);
        step(1, 8'h50, 1, 0, 0); step(0, 0, 1, 0, 0);
        chk("t5 lock", bus.o_lock, 0);
        chk("t5 address_32", bus.o_address_32, 1);
        chk("t5 count", bus.o_prefix_count, 0);
        step(0, 0, 0, 1, 0);

`ifdef DECODE_PREFIX_BRANCH_HINT_EN
        step(1, 8'h3E, 0, 0, 0); step(1, 8'h74, 0, 0, 0); step(0, 0, 0, 0, 0);
        chk("t6 hint_taken", bus.o_hint_taken, 1);
        step(1, 8'h2E, 0, 1, 0); step(1, 8'h8B, 0, 0, 0); step(0, 0, 0, 0, 0);
        chk("t6 hints clear", {bus.o_hint_taken, bus.o_hint_not_taken}, 0);
        step(0, 0, 0, 1, 0);
`endif

        // randomized mix, then prefix-heavy to reach overflow
        for (int i = 0; i < 1500; i++) begin
            int pct;
            pct = (i < 900) ? 45 : 93;
            b = ($urandom_range(0, 99) < pct) ? pfx_tab[$urandom_range(0, 10)] : 8'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, b, 1'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) < 3);
        end
        step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);

        // reset in the middle of accumulation
        step(1, 8'h66, 0, 0, 0); step(1, 8'hF0, 0, 0, 0);
        @(negedge clk);
        live = 0; bus.i_valid = 0; rst = 1;
        pend.delete(); q.delete();
        #1;
        chk("midreset lock", bus.o_lock, 0);
        chk("midreset count", bus.o_prefix_count, 0);
        chk("midreset ready", bus.o_ready, 0);
        @(negedge clk); rst = 0;
        @(negedge clk); @(negedge clk);
        chk("post reset ready", bus.o_ready, 1);
        chk("post reset valid", bus.o_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
